px_col_assembler: RTL and testbench
===================================

Name: px_col_assembler

Overview:
- Parametrised successor to the CCM pixel allocator.
- Gathers per-decoder (lane) pixel streams into full-width columns, indexed by absolute column number.
- Inserts all-zero columns for column indices no lane produces (zero padding, zero skipping).
- Buffers columns in a DEPTH-entry FIFO that the PE array drains one column per pop.
- Sits between the sparse decoders and the compute column feed in CCM.

Parameters:
LANES, 8, number of decoder lanes (pixels per column)
PX_W, 16, pixel width in bits
COL_W, 16, column index width (fully-connected support)
DEPTH, 16, FIFO depth in columns; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  clear FIFO, column counter and error flag
push_col  in  1  request to assemble the next non-zero column
pop_col  in  1  consume the head column
dec_enabled  in  LANES  lane enable mask
px_vld  in  LANES  lane pixel/column valid
px_col  in  LANES*COL_W  lane column index; lane 0 in MSBs
dec_px_in  in  LANES*PX_W  lane pixel; lane 0 in MSBs
px_rdy  out  LANES  per-lane consume pulse
out_pixels  out  LANES*PX_W  head column; lane 0 in MSBs
out_valid  out  1  FIFO not empty
full  out  1  count == DEPTH
count  out  clog2(DEPTH)+1  occupancy
col_cnt  out  COL_W  next column index to be written
err_stale  out  1  sticky stale-column error

Behaviour:
- Reset (rst high at posedge) has priority over everything. It clears:
  - state to IDLE
  - head, tail, count, col_cnt to 0
  - px_rdy and err_stale to 0
  - After reset: out_valid=0, full=0. Memory contents are not reset.
  - A reset mid-assembly abandons the request.
- Flush is the next priority and applies in any state:
  - Same clears as reset.
  - pop_col and push_col are ignored in the flush cycle.
- Per-lane match: match[i] = dec_enabled[i] & px_vld[i] & (px_col[i] == col_cnt).
- ready_all = &(px_vld | ~dec_enabled).
- States:
  - IDLE:
    - push_col=1 and dec_enabled != 0 -> RUN next cycle.
    - push_col with dec_enabled == 0 is ignored.
    - push_col while in RUN is ignored; requests are not queued.
  - RUN, evaluated every cycle. The full check uses the start-of-cycle count; a same-cycle pop does not free space.
    - If full or !ready_all: stall, no write.
    - Else if any match[i]:
      - Write column at tail: slot i = pixel of lane i if match[i], else 0.
      - px_rdy = match for exactly this cycle.
      - tail++, col_cnt++, go to IDLE (request complete).
    - Else: write an all-zero column, tail++, col_cnt++, stay in RUN. Zero fill runs at one column per cycle.
- Latency:
  - push_col in cycle t -> earliest write at the edge ending cycle t+1.
  - out_valid rises at t+2.
- Stale detection: in RUN, with ready_all, any enabled lane with px_col < col_cnt sets err_stale. err_stale stays set until flush or reset. Assembly continues; that lane can never match.
- Pop: pop_col & !empty -> head++ at the edge.
  - Pop when empty is ignored.
  - Pop is allowed in every state except during flush.
- count: +1 on write, -1 on pop, unchanged on a simultaneous write and pop.
- head and tail wrap modulo DEPTH.
- col_cnt wraps 2^COL_W-1 -> 0 silently.
- out_pixels = mem[head], combinational; undefined content when out_valid=0.
- px_rdy is 0 outside a matching RUN write.

Test Plan:
- LANES=8, DEPTH=16. After reset, all lanes enabled and valid with px_col=0, pulse push_col -> one write 2 cycles later with out_pixels=dec_px_in, px_rdy=8'hFF for 1 cycle, count=1, col_cnt=1.
- col_cnt=1, lane 3 px_col=1, other lanes px_col=4, push_col -> column {0,0,0,pix3,0,0,0,0}, px_rdy=8'h10, col_cnt=2; next push writes 2 zero columns (indices 2,3) then one at index 4 with lanes 0-2,4-7 filled; count +3.
- Fill to count=15, push_col with all lanes px_col=col_cnt+5 -> one zero column written, full=1, FSM stalls in RUN. Pop once -> zero fill resumes next cycle.
- Simultaneous pop and matching write at count=5 -> count stays 5, head and tail both advance. Pop at count=0 -> no change.
- Enabled lane 2 with px_col < col_cnt, others matching -> err_stale=1 and stays set. Flush -> err_stale=0, count=0, col_cnt=0, FSM in IDLE; a pop_col in the flush cycle is ignored.
- rst asserted during zero-fill RUN -> next cycle all outputs at reset values. A push_col with dec_enabled=0 -> no state change.

Source files
------------

// File: rtl/px_col_assembler_if.sv
// Bus bundle between the sparse decoder lanes, the column assembler and the PE column feed.
// Lane 0 occupies the most-significant slot of every per-lane vector.
interface px_col_assembler_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned PX_W  = 16,
    parameter int unsigned COL_W = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                     flush;
    logic                     push_col;
    logic                     pop_col;
    logic [LANES-1:0]         dec_enabled;
    logic [LANES-1:0]         px_vld;
    logic [LANES*COL_W-1:0]   px_col;
    logic [LANES*PX_W-1:0]    dec_px_in;
    logic [LANES-1:0]         px_rdy;
    logic [LANES*PX_W-1:0]    out_pixels;
    logic                     out_valid;
    logic                     full;
    logic [CNT_W-1:0]         count;
    logic [COL_W-1:0]         col_cnt;
    logic                     err_stale;

    modport master (
        output flush, push_col, pop_col, dec_enabled, px_vld, px_col, dec_px_in,
        input  px_rdy, out_pixels, out_valid, full, count, col_cnt, err_stale
    );

    modport slave (
        input  flush, push_col, pop_col, dec_enabled, px_vld, px_col, dec_px_in,
        output px_rdy, out_pixels, out_valid, full, count, col_cnt, err_stale
    );
endinterface

// File: rtl/px_col_assembler.sv
// Gathers per-lane decoder pixels into full-width columns by absolute column index,
// zero-filling skipped indices, and queues them in a FIFO for the PE array.
module px_col_assembler #(
    parameter int unsigned LANES = 8,
    parameter int unsigned PX_W  = 16,
    parameter int unsigned COL_W = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    px_col_assembler_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ROW_W = LANES * PX_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ROW_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [COL_W-1:0]   col_cnt_q;
    logic [LANES-1:0]   px_rdy_q;
    logic               err_stale_q;

    logic [LANES-1:0]   match_c;
    logic [LANES-1:0]   stale_c;
    logic [ROW_W-1:0]   wr_col_c;
    logic               ready_all_c;
    logic               any_en_c;
    logic               full_c;
    logic               empty_c;
    logic               wr_en_c;
    logic               rd_en_c;
    logic               stale_hit_c;

    // Per-lane column compare; bit B of each mask and slot B of each bus belong to lane g.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int unsigned B = LANES - 1 - g;
        logic [COL_W-1:0] lane_col;

        assign lane_col          = bus.px_col[B*COL_W +: COL_W];
        assign match_c[B]        = bus.dec_enabled[B] & bus.px_vld[B] & (lane_col == col_cnt_q);
        assign stale_c[B]        = bus.dec_enabled[B] & (lane_col < col_cnt_q);
        assign wr_col_c[B*PX_W +: PX_W] = match_c[B] ? bus.dec_px_in[B*PX_W +: PX_W] : PX_W'(0);
    end

    assign ready_all_c = &(bus.px_vld | ~bus.dec_enabled);
    assign any_en_c    = |bus.dec_enabled;
    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign empty_c     = (count_q == CNT_W'(0));
    assign rd_en_c     = bus.pop_col & ~empty_c & ~bus.flush;
    assign stale_hit_c = (state_q == RUN) & ready_all_c & (|stale_c) & ~bus.flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and column write enable
    always_comb begin
        state_d = state_q;
        wr_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.push_col && any_en_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Stall on a full FIFO (start-of-cycle count) or while any enabled lane is not yet valid.
                if (!full_c && ready_all_c) begin
                    wr_en_c = 1'b1;
                    if (|match_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            wr_en_c = 1'b0;
        end
    end

    // Column storage; contents are deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (wr_en_c && !rst) begin
            mem[tail_q] <= wr_col_c;
        end
    end

    // Pointers, occupancy, column counter, consume pulse and sticky error
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            col_cnt_q   <= '0;
            px_rdy_q    <= '0;
            err_stale_q <= 1'b0;
        end else begin
            px_rdy_q <= wr_en_c ? match_c : '0;
            if (wr_en_c) begin
                tail_q    <= tail_q + PTR_W'(1);
                col_cnt_q <= col_cnt_q + COL_W'(1);
            end
            if (rd_en_c) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({wr_en_c, rd_en_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (stale_hit_c) begin
                err_stale_q <= 1'b1;
            end
        end
    end

    assign bus.px_rdy     = px_rdy_q;
    assign bus.out_pixels = mem[head_q];
    assign bus.out_valid  = ~empty_c;
    assign bus.full       = full_c;
    assign bus.count      = count_q;
    assign bus.col_cnt    = col_cnt_q;
    assign bus.err_stale  = err_stale_q;

endmodule

// File: tb/tb_px_col_assembler.sv
// Scenario bench for px_col_assembler: expected columns are queued when requests are driven
// and compared against the FIFO head as columns are popped.
module tb_px_col_assembler;
    localparam int unsigned LANES = 8;
    localparam int unsigned PX_W  = 16;
    localparam int unsigned COL_W = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ROW_W = LANES * PX_W;

    logic clk;
    logic rst;

    px_col_assembler_if #(.LANES(LANES), .PX_W(PX_W), .COL_W(COL_W), .DEPTH(DEPTH)) bus ();

    px_col_assembler #(.LANES(LANES), .PX_W(PX_W), .COL_W(COL_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [ROW_W-1:0] sb[$];
    logic [ROW_W-1:0] exp_row;

    logic             en  [LANES];
    logic             vld [LANES];
    logic [COL_W-1:0] lc  [LANES];
    logic [PX_W-1:0]  lp  [LANES];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack the lane arrays onto the bus, lane 0 in the most-significant slot.
    task automatic drive_lanes();
        logic [ROW_W-1:0]       p;
        logic [LANES*COL_W-1:0] c;
        logic [LANES-1:0]       e;
        logic [LANES-1:0]       v;
        p = '0; c = '0; e = '0; v = '0;
        for (int i = 0; i < LANES; i++) begin
            p = {p[ROW_W-PX_W-1:0], lp[i]};
            c = {c[LANES*COL_W-COL_W-1:0], lc[i]};
            e = {e[LANES-2:0], en[i]};
            v = {v[LANES-2:0], vld[i]};
        end
        bus.dec_px_in   = p;
        bus.px_col      = c;
        bus.dec_enabled = e;
        bus.px_vld      = v;
    endtask

    task automatic set_all(input logic [COL_W-1:0] col, input logic [PX_W-1:0] base);
        for (int i = 0; i < LANES; i++) begin
            en[i]  = 1'b1;
            vld[i] = 1'b1;
            lc[i]  = col;
            lp[i]  = base + PX_W'(i);
        end
    endtask

    // Expected column from the current lane pixels; mask bit (LANES-1-i) selects lane i.
    function automatic logic [ROW_W-1:0] exp_col(input logic [LANES-1:0] m);
        logic [ROW_W-1:0] r;
        logic [LANES-1:0] mm;
        r  = '0;
        mm = m;
        for (int i = 0; i < LANES; i++) begin
            r  = {r[ROW_W-PX_W-1:0], mm[LANES-1] ? lp[i] : PX_W'(0)};
            mm = mm << 1;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b exp 0", bus.full); end
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(0)) begin n_fail++; $display("FAIL reset_col_cnt: got %0d exp 0", bus.col_cnt); end
        n_tests++; if (bus.px_rdy !== 8'h00) begin n_fail++; $display("FAIL reset_px_rdy: got %h exp 00", bus.px_rdy); end
        n_tests++; if (bus.err_stale !== 1'b0) begin n_fail++; $display("FAIL reset_err_stale: got %b exp 0", bus.err_stale); end
    endtask

    task automatic test_basic();
        set_all(COL_W'(0), 16'hA000);
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back(exp_col(8'hFF));
        tick();
        bus.push_col = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL basic_latency_count: got %0d exp 0", bus.count); end
        tick();
        n_tests++; if (bus.count !== CNT_W'(1)) begin n_fail++; $display("FAIL basic_count: got %0d exp 1", bus.count); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b exp 1", bus.out_valid); end
        n_tests++; if (bus.px_rdy !== 8'hFF) begin n_fail++; $display("FAIL basic_px_rdy: got %h exp ff", bus.px_rdy); end
        n_tests++; if (bus.col_cnt !== COL_W'(1)) begin n_fail++; $display("FAIL basic_col_cnt: got %0d exp 1", bus.col_cnt); end
        tick();
        n_tests++; if (bus.px_rdy !== 8'h00) begin n_fail++; $display("FAIL basic_px_rdy_pulse: got %h exp 00", bus.px_rdy); end
        exp_row = sb.pop_front();
        n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL basic_out_pixels: got %h exp %h", bus.out_pixels, exp_row); end
        bus.pop_col = 1'b1;
        tick();
        bus.pop_col = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL basic_pop_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_sparse();
        set_all(COL_W'(4), 16'h1000);
        lc[3] = COL_W'(1);
        lp[3] = 16'h3333;
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back(exp_col(8'h10));
        tick();
        bus.push_col = 1'b0;
        tick();
        n_tests++; if (bus.px_rdy !== 8'h10) begin n_fail++; $display("FAIL sparse_px_rdy: got %h exp 10", bus.px_rdy); end
        n_tests++; if (bus.col_cnt !== COL_W'(2)) begin n_fail++; $display("FAIL sparse_col_cnt: got %0d exp 2", bus.col_cnt); end
        n_tests++; if (bus.count !== CNT_W'(1)) begin n_fail++; $display("FAIL sparse_count: got %0d exp 1", bus.count); end
        lc[3] = COL_W'(5);
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back('0);
        sb.push_back('0);
        sb.push_back(exp_col(8'hEF));
        tick();
        bus.push_col = 1'b0;
        tick();
        tick();
        tick();
        n_tests++; if (bus.count !== CNT_W'(4)) begin n_fail++; $display("FAIL skip_count: got %0d exp 4", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(5)) begin n_fail++; $display("FAIL skip_col_cnt: got %0d exp 5", bus.col_cnt); end
        n_tests++; if (bus.px_rdy !== 8'hEF) begin n_fail++; $display("FAIL skip_px_rdy: got %h exp ef", bus.px_rdy); end
        tick();
        n_tests++; if (bus.count !== CNT_W'(4)) begin n_fail++; $display("FAIL skip_idle_count: got %0d exp 4", bus.count); end
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            if (bus.out_valid) begin
                exp_row = sb.pop_front();
                n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL sparse_drain: got %h exp %h", bus.out_pixels, exp_row); end
                bus.pop_col = 1'b1;
            end else begin
                bus.pop_col = 1'b0;
            end
            tick();
        end
        bus.pop_col = 1'b0;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sparse_drain_timeout: got %0d left exp 0", sb.size()); end
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL sparse_drain_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.err_stale !== 1'b0) begin n_fail++; $display("FAIL sparse_err_stale: got %b exp 0", bus.err_stale); end
    endtask

    task automatic test_full();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        sb.delete();
        set_all(COL_W'(14), 16'hB000);
        drive_lanes();
        bus.push_col = 1'b1;
        for (int k = 0; k < 14; k++) sb.push_back('0);
        sb.push_back(exp_col(8'hFF));
        tick();
        bus.push_col = 1'b0;
        repeat (15) tick();
        n_tests++; if (bus.count !== CNT_W'(15)) begin n_fail++; $display("FAIL fill_count: got %0d exp 15", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(15)) begin n_fail++; $display("FAIL fill_col_cnt: got %0d exp 15", bus.col_cnt); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b exp 0", bus.full); end
        set_all(COL_W'(20), 16'hC000);
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back('0);
        tick();
        bus.push_col = 1'b0;
        tick();
        n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b exp 1", bus.full); end
        n_tests++; if (bus.count !== CNT_W'(16)) begin n_fail++; $display("FAIL full_count: got %0d exp 16", bus.count); end
        repeat (3) tick();
        n_tests++; if (bus.col_cnt !== COL_W'(16)) begin n_fail++; $display("FAIL full_stall_col_cnt: got %0d exp 16", bus.col_cnt); end
        n_tests++; if (bus.count !== CNT_W'(16)) begin n_fail++; $display("FAIL full_stall_count: got %0d exp 16", bus.count); end
        exp_row = sb.pop_front();
        n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL full_head: got %h exp %h", bus.out_pixels, exp_row); end
        bus.pop_col = 1'b1;
        tick();
        bus.pop_col = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(15)) begin n_fail++; $display("FAIL full_pop_count: got %0d exp 15", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(16)) begin n_fail++; $display("FAIL full_pop_no_write: got %0d exp 16", bus.col_cnt); end
        tick();
        n_tests++; if (bus.count !== CNT_W'(16)) begin n_fail++; $display("FAIL full_resume_count: got %0d exp 16", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(17)) begin n_fail++; $display("FAIL full_resume_col_cnt: got %0d exp 17", bus.col_cnt); end
        for (int k = 0; k < 4; k++) sb.push_back('0);
        sb.push_back(exp_col(8'hFF));
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            if (bus.out_valid) begin
                exp_row = sb.pop_front();
                n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL full_drain: got %h exp %h", bus.out_pixels, exp_row); end
                bus.pop_col = 1'b1;
            end else begin
                bus.pop_col = 1'b0;
            end
            tick();
        end
        bus.pop_col = 1'b0;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout: got %0d left exp 0", sb.size()); end
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL full_drain_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(21)) begin n_fail++; $display("FAIL full_drain_col_cnt: got %0d exp 21", bus.col_cnt); end
    endtask

    task automatic test_back_to_back();
        set_all(COL_W'(21), 16'hD000);
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back(exp_col(8'hFF));
        tick();
        bus.push_col = 1'b0;
        tick();
        set_all(COL_W'(25), 16'hF000);
        drive_lanes();
        bus.push_col = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('0);
        sb.push_back(exp_col(8'hFF));
        tick();
        bus.push_col = 1'b0;
        repeat (4) tick();
        n_tests++; if (bus.count !== CNT_W'(5)) begin n_fail++; $display("FAIL b2b_count: got %0d exp 5", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(26)) begin n_fail++; $display("FAIL b2b_col_cnt: got %0d exp 26", bus.col_cnt); end
        set_all(COL_W'(26), 16'hE000);
        drive_lanes();
        bus.push_col = 1'b1;
        tick();
        bus.push_col = 1'b0;
        exp_row = sb.pop_front();
        n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL simul_head: got %h exp %h", bus.out_pixels, exp_row); end
        bus.pop_col = 1'b1;
        sb.push_back(exp_col(8'hFF));
        tick();
        bus.pop_col = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(5)) begin n_fail++; $display("FAIL simul_count: got %0d exp 5", bus.count); end
        n_tests++; if (bus.px_rdy !== 8'hFF) begin n_fail++; $display("FAIL simul_px_rdy: got %h exp ff", bus.px_rdy); end
        n_tests++; if (bus.col_cnt !== COL_W'(27)) begin n_fail++; $display("FAIL simul_col_cnt: got %0d exp 27", bus.col_cnt); end
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            if (bus.out_valid) begin
                exp_row = sb.pop_front();
                n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL simul_drain: got %h exp %h", bus.out_pixels, exp_row); end
                bus.pop_col = 1'b1;
            end else begin
                bus.pop_col = 1'b0;
            end
            tick();
        end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL simul_drain_timeout: got %0d left exp 0", sb.size()); end
        bus.pop_col = 1'b1;
        tick();
        bus.pop_col = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL empty_pop_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_stale_flush();
        set_all(COL_W'(27), 16'h5000);
        lc[2] = COL_W'(3);
        drive_lanes();
        bus.push_col = 1'b1;
        sb.push_back(exp_col(8'hDF));
        tick();
        bus.push_col = 1'b0;
        tick();
        n_tests++; if (bus.err_stale !== 1'b1) begin n_fail++; $display("FAIL stale_set: got %b exp 1", bus.err_stale); end
        n_tests++; if (bus.px_rdy !== 8'hDF) begin n_fail++; $display("FAIL stale_px_rdy: got %h exp df", bus.px_rdy); end
        exp_row = sb.pop_front();
        n_tests++; if (bus.out_pixels !== exp_row) begin n_fail++; $display("FAIL stale_column: got %h exp %h", bus.out_pixels, exp_row); end
        repeat (3) tick();
        n_tests++; if (bus.err_stale !== 1'b1) begin n_fail++; $display("FAIL stale_sticky: got %b exp 1", bus.err_stale); end
        bus.flush   = 1'b1;
        bus.pop_col = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.pop_col = 1'b0;
        sb.delete();
        n_tests++; if (bus.err_stale !== 1'b0) begin n_fail++; $display("FAIL flush_err_stale: got %b exp 0", bus.err_stale); end
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(0)) begin n_fail++; $display("FAIL flush_col_cnt: got %0d exp 0", bus.col_cnt); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b exp 0", bus.out_valid); end
        repeat (2) tick();
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL flush_idle_count: got %0d exp 0", bus.count); end
    endtask

    task automatic test_reset_mid_run();
        set_all(COL_W'(10), 16'h7000);
        drive_lanes();
        bus.push_col = 1'b1;
        tick();
        bus.push_col = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.count !== CNT_W'(2)) begin n_fail++; $display("FAIL midrst_pre_count: got %0d exp 2", bus.count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(0)) begin n_fail++; $display("FAIL midrst_col_cnt: got %0d exp 0", bus.col_cnt); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b exp 0", bus.full); end
        n_tests++; if (bus.px_rdy !== 8'h00) begin n_fail++; $display("FAIL midrst_px_rdy: got %h exp 00", bus.px_rdy); end
        repeat (2) tick();
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL midrst_abandon: got %0d exp 0", bus.count); end
        for (int i = 0; i < LANES; i++) en[i] = 1'b0;
        drive_lanes();
        bus.push_col = 1'b1;
        tick();
        bus.push_col = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            en[i] = 1'b1;
            lc[i] = COL_W'(3);
        end
        drive_lanes();
        repeat (3) tick();
        n_tests++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL noen_push_count: got %0d exp 0", bus.count); end
        n_tests++; if (bus.col_cnt !== COL_W'(0)) begin n_fail++; $display("FAIL noen_push_col_cnt: got %0d exp 0", bus.col_cnt); end
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.push_col     = 1'b0;
        bus.pop_col      = 1'b0;
        bus.dec_enabled  = '0;
        bus.px_vld       = '0;
        bus.px_col       = '0;
        bus.dec_px_in    = '0;
        for (int i = 0; i < LANES; i++) begin
            en[i]  = 1'b0;
            vld[i] = 1'b0;
            lc[i]  = '0;
            lp[i]  = '0;
        end
        test_reset();
        test_basic();
        test_sparse();
        test_full();
        test_back_to_back();
        test_stale_flush();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
